alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the 4-bit ALU control decoder. Decodes {ALUOp, funct7[1:0], funct3}
//  into an ALU control code and executes the operation on XLEN-bit operands.
//  Add, sub, xor and branch compares complete in one cycle. Mult is iterative, radix 2^MUL_STEP.
//  Sits in the EX stage and talks to the pipeline through a valid/ready handshake.
// PARAMETERS
//  XLEN      32  operand/result width; must be a multiple of MUL_STEP, >= 8
//  MUL_STEP   2  multiplier bits retired per cycle (1, 2 or 4); MUL latency K = XLEN/MUL_STEP
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     asynchronous, active-low reset
//  flush        in   1     synchronous abort of any in-flight op
//  in_valid     in   1     operation request
//  in_ready     out  1     unit idle; request accepted when in_valid & in_ready
//  ALUOp        in   2     00 ld/st, 01 branch, 10 R-type, 11 addi
//  funct7       in   2     compressed funct7 (bit1 = sub, bit0 = mul)
//  funct3       in   3     instruction funct3
//  op_a, op_b   in   XLEN  operands, sampled only at accept
//  out_valid    out  1     result valid; held until out_ready
//  out_ready    in   1     consumer takes result
//  result       out  XLEN  operation result
//  alu_ctrl     out  4     decoded control code of the completed op
//  zero         out  1     result == 0
//  br_taken     out  1     branch condition true (beq/bge only, else 0)
//  illegal      out  1     op did not decode
// BEHAVIOUR
//  Reset: state IDLE. out_valid, result, alu_ctrl, zero, br_taken, illegal all 0. in_ready = 1.
//  Decode at accept (ctrl code / result):
//   - 00 or 11 -> 2 / a+b.
//   - 01: f3=0 -> 5 / a-b, br_taken=(a==b). f3=5 -> 7 / a-b, br_taken=($signed(a)>=$signed(b)).
//   - 10: {f7,f3}=00000 -> 2 add. 00100 -> 4 xor. 10000 -> 6 a-b. 01000 -> 1 MUL.
//     MUL returns the low XLEN bits of a*b.
//   - Any other code -> illegal=1, alu_ctrl=4'hF, result=0. Completes like a 1-cycle op.
//  Arithmetic wraps mod 2^XLEN; no overflow flag. zero is computed from the final result.
//  FSM:
//   - IDLE: in_ready=1. On accept of a 1-cycle op -> DONE with outputs loaded at the same edge.
//     On accept of MUL -> MUL, loading the multiplicand, multiplier, acc=0 and cnt=K.
//   - MUL: in_ready=0. Each edge adds MUL_STEP partial products and decrements cnt.
//     On the edge where cnt goes 1->0 -> DONE with result=acc.
//   - DONE: out_valid=1, outputs stable. On out_ready -> IDLE.
//     No same-cycle re-accept: in_ready=0 while in DONE.
//  Latency from the accept edge: 1-cycle ops show out_valid right after that edge.
//  MUL shows out_valid after K further edges.
//  in_valid is ignored while in_ready=0. Operands are not re-sampled after accept.
//  flush overrides everything:
//   - Next edge goes to IDLE and out_valid=0. Result regs may keep stale data; only out_valid matters.
//   - A flush and in_valid in the same IDLE cycle: the request is dropped.
//  reset_n low at any time, including mid-MUL: immediate return to the reset values. cnt and acc are cleared.
//  out_ready while out_valid=0 has no effect.
// TESTING
//  1. Reset, then add a=7 b=5 -> out_valid next cycle, result=12, alu_ctrl=2, zero=0.
//  2. sub a=5 b=5 ({f7,f3}=10000) -> result=0, zero=1, alu_ctrl=6.
//     bge a=-3 b=2 -> br_taken=0, alu_ctrl=7.
//  3. MUL a=32'hFFFF_FFFF b=3, XLEN=32, MUL_STEP=2 -> out_valid exactly 16 edges after accept.
//     result=32'hFFFF_FFFD, in_ready=0 throughout.
//  4. Hold out_ready=0 for 5 cycles in DONE -> result stable, in_valid ignored.
//     Raise out_ready -> IDLE next edge.
//  5. ALUOp=01 f3=3 -> illegal=1, alu_ctrl=F, result=0, br_taken=0.
//     Repeat with {f7,f3}=11111 -> same response.
//  6. Start MUL, assert flush at step 4 -> IDLE, out_valid never rises.
//     Repeat with reset_n pulsed low mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes {ALUOp, funct7, funct3} and executes add/sub/xor/branch in one
// cycle or an iterative radix-2^MUL_STEP multiply, behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [1:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_ctrl,
    output logic            zero,
    output logic            br_taken,
    output logic            illegal,
    output logic [1:0]      dbg_state
);
    localparam int K     = XLEN / MUL_STEP;
    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [XLEN-1:0]  mcand, mplier, acc, step_sum;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic [XLEN-1:0] dec_result, diff;
    logic [3:0]      dec_ctrl;
    logic            dec_br, dec_illegal, dec_is_mul;

    // Handshake: a request transfers on a rising edge where in_valid & in_ready and no flush;
    // a result transfers on a rising edge where out_valid & out_ready. out_valid holds until then.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready & ~flush;
    assign dbg_state = state;
    assign diff      = op_a - op_b;

    always_comb begin
        dec_ctrl    = 4'hF;
        dec_result  = '0;
        dec_br      = 1'b0;
        dec_illegal = 1'b1;
        dec_is_mul  = 1'b0;
        case (ALUOp)
            2'b00, 2'b11: begin
                dec_ctrl = 4'd2; dec_result = op_a + op_b; dec_illegal = 1'b0;
            end
            2'b01: begin
                if (funct3 == 3'd0) begin
                    dec_ctrl = 4'd5; dec_result = diff; dec_illegal = 1'b0;
                    dec_br = (op_a == op_b);
                end else if (funct3 == 3'd5) begin
                    dec_ctrl = 4'd7; dec_result = diff; dec_illegal = 1'b0;
                    dec_br = ($signed(op_a) >= $signed(op_b));
                end
            end
            default: begin
                case ({funct7, funct3})
                    5'b00000: begin dec_ctrl = 4'd2; dec_result = op_a + op_b; dec_illegal = 1'b0; end
                    5'b00100: begin dec_ctrl = 4'd4; dec_result = op_a ^ op_b; dec_illegal = 1'b0; end
                    5'b10000: begin dec_ctrl = 4'd6; dec_result = diff;        dec_illegal = 1'b0; end
                    5'b01000: begin dec_ctrl = 4'd1; dec_is_mul = 1'b1;        dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

    // One radix step: add the next MUL_STEP shifted partial products of the multiplier.
    always_comb begin
        step_sum = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) step_sum = step_sum + (mcand << i);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = dec_is_mul ? S_MUL : S_DONE;
            S_MUL:   if (cnt == CNT_W'(1)) state_n = S_DONE;
            S_DONE:  if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            alu_ctrl <= '0;
            zero     <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                if (dec_is_mul) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    acc    <= '0;
                    cnt    <= CNT_W'(K);
                end else begin
                    result   <= dec_result;
                    alu_ctrl <= dec_ctrl;
                    zero     <= (dec_result == '0);
                    br_taken <= dec_br;
                    illegal  <= dec_illegal;
                end
            end
            if (state == S_MUL) begin
                acc    <= step_sum;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    result   <= step_sum;
                    alu_ctrl <= 4'd1;
                    zero     <= (step_sum == '0);
                    br_taken <= 1'b0;
                    illegal  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, MUL_STEP=2): one task per scenario.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ALUOp = 2'b00;
    logic [1:0]  funct7 = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0, op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  alu_ctrl;
    logic        zero, br_taken, illegal;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    alu_exec_unit #(.XLEN(32), .MUL_STEP(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .alu_ctrl(alu_ctrl),
        .zero(zero), .br_taken(br_taken), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Driver: present a request for one cycle; returns 1 time unit after the accept edge.
    task automatic send(input logic [1:0] op, input logic [1:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUOp = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        tests_run++;
        if ({in_ready, out_valid, result, alu_ctrl, zero, br_taken, illegal, dbg_state} !==
            {1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h ctrl=%h z=%b br=%b ill=%b st=%0d exp rdy=1 rest 0",
                     in_ready, out_valid, result, alu_ctrl, zero, br_taken, illegal, dbg_state);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_add();
        send(2'b10, 2'b00, 3'd0, 32'd7, 32'd5);
        @(negedge clk);
        tests_run++;
        if ({out_valid, in_ready, result, alu_ctrl, zero} !== {1'b1, 1'b0, 32'd12, 4'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_7_5 got vld=%b rdy=%b res=%0d ctrl=%0d z=%b exp vld=1 rdy=0 res=12 ctrl=2 z=0",
                     out_valid, in_ready, result, alu_ctrl, zero);
        end
        release_result();
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL add_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
        send(2'b00, 2'b11, 3'd7, 32'd100, 32'hFFFF_FFFC);
        @(negedge clk);
        tests_run++;
        if ({result, alu_ctrl} !== {32'd96, 4'd2}) begin
            tests_failed++;
            $display("FAIL ldst_add got res=%h ctrl=%0d exp res=00000060 ctrl=2", result, alu_ctrl);
        end
        release_result();
        send(2'b11, 2'b00, 3'd0, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        tests_run++;
        if ({result, alu_ctrl, zero} !== {32'd0, 4'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL addi_wrap got res=%h ctrl=%0d z=%b exp res=0 ctrl=2 z=1", result, alu_ctrl, zero);
        end
        release_result();
    endtask

    task automatic test_sub_xor_branch();
        send(2'b10, 2'b10, 3'd0, 32'd5, 32'd5);
        @(negedge clk);
        tests_run++;
        if ({result, alu_ctrl, zero} !== {32'd0, 4'd6, 1'b1}) begin
            tests_failed++;
            $display("FAIL sub_5_5 got res=%h ctrl=%0d z=%b exp res=0 ctrl=6 z=1", result, alu_ctrl, zero);
        end
        release_result();
        send(2'b10, 2'b00, 3'd4, 32'h0000_F0F0, 32'h0000_FF00);
        @(negedge clk);
        tests_run++;
        if ({result, alu_ctrl} !== {32'h0000_0FF0, 4'd4}) begin
            tests_failed++;
            $display("FAIL xor got res=%h ctrl=%0d exp res=00000ff0 ctrl=4", result, alu_ctrl);
        end
        release_result();
        send(2'b01, 2'b00, 3'd0, 32'd9, 32'd9);
        @(negedge clk);
        tests_run++;
        if ({br_taken, alu_ctrl, result} !== {1'b1, 4'd5, 32'd0}) begin
            tests_failed++;
            $display("FAIL beq_eq got br=%b ctrl=%0d res=%h exp br=1 ctrl=5 res=0", br_taken, alu_ctrl, result);
        end
        release_result();
        send(2'b01, 2'b00, 3'd5, 32'hFFFF_FFFD, 32'd2);
        @(negedge clk);
        tests_run++;
        if ({br_taken, alu_ctrl, result} !== {1'b0, 4'd7, 32'hFFFF_FFFB}) begin
            tests_failed++;
            $display("FAIL bge_neg got br=%b ctrl=%0d res=%h exp br=0 ctrl=7 res=fffffffb", br_taken, alu_ctrl, result);
        end
        release_result();
        send(2'b01, 2'b00, 3'd5, 32'd2, 32'hFFFF_FFFD);
        @(negedge clk);
        tests_run++;
        if (br_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL bge_pos got br=%b exp br=1", br_taken);
        end
        release_result();
    endtask

    task automatic test_mul();
        int  edges;
        logic rdy_bad;
        edges = 0;
        rdy_bad = 1'b0;
        send(2'b10, 2'b01, 3'd0, 32'hFFFF_FFFF, 32'd3);
        while (edges < 40) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk);
            #1 edges++;
            if (out_valid === 1'b1) break;
        end
        tests_run++;
        if (edges != 16 || rdy_bad) begin
            tests_failed++;
            $display("FAIL mul_latency got edges=%0d rdy_seen_high=%b exp edges=16 rdy_seen_high=0", edges, rdy_bad);
        end
        tests_run++;
        if ({result, alu_ctrl, zero} !== {32'hFFFF_FFFD, 4'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mul_result got res=%h ctrl=%0d z=%b exp res=fffffffd ctrl=1 z=0", result, alu_ctrl, zero);
        end
        release_result();
    endtask

    task automatic test_hold();
        logic bad;
        bad = 1'b0;
        send(2'b10, 2'b00, 3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'd7 || alu_ctrl !== 4'd2) bad = 1'b1;
            ALUOp = 2'b10; funct7 = 2'b10; funct3 = 3'd0; op_a = 32'd100; op_b = 32'd1;
            in_valid = 1'b1;
        end
        @(negedge clk);
        if (out_valid !== 1'b1 || result !== 32'd7 || alu_ctrl !== 4'd2) bad = 1'b1;
        in_valid = 1'b0;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL hold_stable got vld=%b res=%0d ctrl=%0d during stall exp vld=1 res=7 ctrl=2",
                     out_valid, result, alu_ctrl);
        end
        release_result();
        tests_run++;
        if ({out_valid, in_ready, dbg_state} !== {1'b0, 1'b1, 2'd0}) begin
            tests_failed++;
            $display("FAIL hold_release got vld=%b rdy=%b st=%0d exp vld=0 rdy=1 st=0", out_valid, in_ready, dbg_state);
        end
    endtask

    task automatic test_illegal();
        send(2'b01, 2'b00, 3'd3, 32'd9, 32'd9);
        @(negedge clk);
        tests_run++;
        if ({out_valid, illegal, alu_ctrl, result, br_taken} !== {1'b1, 1'b1, 4'hF, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL illegal_br3 got vld=%b ill=%b ctrl=%h res=%h br=%b exp vld=1 ill=1 ctrl=f res=0 br=0",
                     out_valid, illegal, alu_ctrl, result, br_taken);
        end
        release_result();
        send(2'b10, 2'b11, 3'd7, 32'd9, 32'd1);
        @(negedge clk);
        tests_run++;
        if ({out_valid, illegal, alu_ctrl, result, br_taken} !== {1'b1, 1'b1, 4'hF, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL illegal_r11111 got vld=%b ill=%b ctrl=%h res=%h br=%b exp vld=1 ill=1 ctrl=f res=0 br=0",
                     out_valid, illegal, alu_ctrl, result, br_taken);
        end
        release_result();
    endtask

    task automatic test_flush_reset();
        logic seen;
        seen = 1'b0;
        send(2'b10, 2'b01, 3'd0, 32'd1234, 32'd5678);
        repeat (3) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        tests_run++;
        if ({dbg_state, in_ready, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL flush_mul got st=%0d rdy=%b vld=%b exp st=0 rdy=1 vld=0", dbg_state, in_ready, out_valid);
        end
        // flush together with a request in IDLE: request must be dropped
        @(negedge clk);
        ALUOp = 2'b10; funct7 = 2'b00; funct3 = 3'd0; op_a = 32'd1; op_b = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL flush_no_valid got out_valid=1 after flush exp out_valid=0");
        end
        send(2'b01, 2'b00, 3'd5, 32'd5, 32'd2);
        release_result();
        send(2'b10, 2'b01, 3'd0, 32'd6, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, in_ready, result, alu_ctrl, zero, br_taken, illegal, dbg_state} !==
            {1'b0, 1'b1, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_mid_mul got vld=%b rdy=%b res=%h ctrl=%h z=%b br=%b ill=%b st=%0d exp rdy=1 rest 0",
                     out_valid, in_ready, result, alu_ctrl, zero, br_taken, illegal, dbg_state);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        int          waited;
        logic [1:0]  ops_alu [4] = '{2'b10, 2'b10, 2'b10, 2'b10};
        logic [1:0]  ops_f7  [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
        logic [2:0]  ops_f3  [4] = '{3'd0, 3'd0, 3'd4, 3'd0};
        logic [31:0] ops_a   [4] = '{32'd10, 32'd1234, 32'd5, 32'd3};
        logic [31:0] ops_b   [4] = '{32'd20, 32'd5678, 32'd3, 32'd5};
        exp_q.push_back(32'd30);
        exp_q.push_back(32'd7006652);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            send(ops_alu[i], ops_f7[i], ops_f3[i], ops_a[i], ops_b[i]);
            waited = 0;
            while (out_valid !== 1'b1 && waited < 40) begin
                @(posedge clk);
                #1 waited++;
            end
            exp_v = exp_q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || result !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_op%0d got vld=%b res=%h exp vld=1 res=%h", i, out_valid, result, exp_v);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_xor_branch();
        test_mul();
        test_hold();
        test_illegal();
        test_flush_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
